rewire_bit_stream_adapter: RTL and testbench

//   Host-side end of a generated device's one-bit-per-cycle port pair (__in0/__out0).

---
 rtl/rewire_adapter_pkg.sv | 25 ++
 rtl/rewire_bit_deser.sv | 66 ++++++
 rtl/rewire_bit_stream_adapter.sv | 93 +++++++++
 tb/tb_rewire_bit_stream_adapter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rewire_adapter_pkg.sv
// Shared types and constants for the rewire bit-stream adapter.
// REWIRE_ADAPTER_PARITY_EN adds one even-parity bit to every word on the stream.
package rewire_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

`ifdef REWIRE_ADAPTER_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    localparam state_e RST_STATE    = IDLE;
    localparam logic   RST_RX_VALID = 1'b0;
    localparam logic   RST_RX_PERR  = 1'b0;

    function automatic int cnt_w(input int nb, input int lat);
        return $clog2(nb + lat + 1);
    endfunction

endpackage

// File: rtl/rewire_bit_deser.sv
// Captures the device response LSB-first, LATENCY cycles behind the driven bits,
// and flags the cycle of the final capture.
module rewire_bit_deser
    import rewire_adapter_pkg::*;
#(
    parameter int NB      = 8,
    parameter int LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          active_i,
    input  logic          bit_i,
    output logic [NB-1:0] data_o,
    output logic          done_o
);

    localparam int CW = cnt_w(NB, LATENCY);
    localparam logic [CW-1:0] TERM = CW'(NB + LATENCY);
    localparam logic [CW-1:0] LAST = CW'(NB + LATENCY - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [NB-1:0] sh_q, sh_d;
    logic          lat_ok;
    logic          cap;

    // cnt_q counts cycles since the first bit was driven; capture starts once LATENCY has elapsed
    generate
        if (LATENCY == 0) begin : g_lat0
            assign lat_ok = 1'b1;
        end else begin : g_latn
            assign lat_ok = (cnt_q >= CW'(LATENCY));
        end
    endgenerate

    assign cap    = active_i && lat_ok && (cnt_q < TERM);
    assign done_o = cap && (cnt_q == LAST);
    assign data_o = sh_q;

    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        if (start_i) begin
            cnt_d = '0;
            sh_d  = '0;
        end else if (active_i) begin
            if (cnt_q != TERM) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cap) begin
                sh_d = {bit_i, sh_q[NB-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end

endmodule

// File: rtl/rewire_bit_stream_adapter.sv
// Host-side adapter: serializes words LSB-first onto dev_in, deserializes dev_out.
// Define REWIRE_ADAPTER_PARITY_EN to append and check an even-parity bit per word.
module rewire_bit_stream_adapter
    import rewire_adapter_pkg::*;
#(
    parameter int   WORD_W   = 8,
    parameter int   LATENCY  = 1,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [WORD_W-1:0] tx_data,
    output logic              dev_in,
    input  logic              dev_out,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_perr,
    output logic              busy
);

    localparam int NB = WORD_W + PAR_BITS;

    state_e        state_q, state_d;
    logic [NB-1:0] tx_sh_q, tx_sh_d;
    logic [NB-1:0] tx_word;
    logic [NB-1:0] rx_word;
    logic          accept;
    logic          deser_done;

`ifdef REWIRE_ADAPTER_PARITY_EN
    assign tx_word = {^tx_data, tx_data};
    assign rx_perr = (state_q == HOLD) && (^rx_word);
`else
    assign tx_word = tx_data;
    assign rx_perr = RST_RX_PERR;
`endif

    assign accept   = (state_q == IDLE) && tx_valid;
    assign tx_ready = (state_q == IDLE);
    assign rx_valid = (state_q == HOLD);
    assign busy     = (state_q != IDLE);
    assign rx_data  = rx_word[WORD_W-1:0];
    // Shifting IDLE_BIT in from the top leaves the line idle once the word is out
    assign dev_in   = (state_q == SHIFT) ? tx_sh_q[0] : IDLE_BIT;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tx_valid)   state_d = SHIFT;
            SHIFT:   if (deser_done) state_d = HOLD;
            HOLD:    if (rx_ready)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        tx_sh_d = tx_sh_q;
        if (accept) begin
            tx_sh_d = tx_word;
        end else if (state_q == SHIFT) begin
            tx_sh_d = {IDLE_BIT, tx_sh_q[NB-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        tx_sh_q <= tx_sh_d;
    end

    rewire_bit_deser #(
        .NB      (NB),
        .LATENCY (LATENCY)
    ) u_deser (
        .clk      (clk),
        .rst      (rst),
        .start_i  (accept),
        .active_i (state_q == SHIFT),
        .bit_i    (dev_out),
        .data_o   (rx_word),
        .done_o   (deser_done)
    );

endmodule

// File: tb/tb_rewire_bit_stream_adapter.sv
// Bench: instance 0 is a registered loopback (LATENCY=1), instance 1 a combinational inverter (LATENCY=0).
module tb_rewire_bit_stream_adapter;

`ifdef REWIRE_ADAPTER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       tx_valid = '0;
    logic [1:0]       tx_ready;
    logic [1:0][7:0]  tx_data = '0;
    logic [1:0]       dev_in;
    logic             dev_out0;
    logic             dev_out1;
    logic [1:0]       rx_valid;
    logic [1:0]       rx_ready = 2'b11;
    logic [1:0][7:0]  rx_data;
    logic [1:0]       rx_perr;
    logic [1:0]       busy;
    logic             flip_now = 1'b0;
    logic             flip_par = 1'b0;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        dev_out0 <= dev_in[0] ^ flip_now;
    end
    assign dev_out1 = ~dev_in[1];

    rewire_bit_stream_adapter #(.WORD_W(8), .LATENCY(1), .IDLE_BIT(1'b0)) u_loop (
        .clk(clk), .rst(rst), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .tx_data(tx_data[0]), .dev_in(dev_in[0]), .dev_out(dev_out0),
        .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]), .rx_data(rx_data[0]),
        .rx_perr(rx_perr[0]), .busy(busy[0])
    );

    rewire_bit_stream_adapter #(.WORD_W(8), .LATENCY(0), .IDLE_BIT(1'b0)) u_inv (
        .clk(clk), .rst(rst), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .tx_data(tx_data[1]), .dev_in(dev_in[1]), .dev_out(dev_out1),
        .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]), .rx_data(rx_data[1]),
        .rx_perr(rx_perr[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one word into instance d, predict the response, wait for rx_valid and compare.
    task automatic send(input int d, input logic [7:0] w, input string tag);
        exp_t          e;
        exp_t          got;
        logic [NB-1:0] s;
        logic [NB-1:0] r;
        logic [NB-1:0] seen;
        int            n;
        int            lat;
        s = NB'(w);
`ifdef REWIRE_ADAPTER_PARITY_EN
        s[NB-1] = ^w;
`endif
        r = (d == 1) ? ~s : s;
`ifdef REWIRE_ADAPTER_PARITY_EN
        if (d == 0 && flip_par) r[NB-1] = ~r[NB-1];
        e.perr = ^r;
`else
        e.perr = 1'b0;
`endif
        e.data = r[7:0];
        sb.push_back(e);
        lat = (d == 0) ? 1 : 0;

        check({tag, "_tx_ready_idle"}, tx_ready[d], 1);
        tx_valid[d] = 1'b1;
        tx_data[d]  = w;
        tick();
        tx_valid[d] = 1'b0;
        n    = 1;
        seen = '0;
        while (!rx_valid[d] && n < 40) begin
            if (n <= NB) seen[n-1] = dev_in[d];
            flip_now = (d == 0) && flip_par && (n == NB);
            tick();
            n++;
        end
        flip_now = 1'b0;
        check({tag, "_latency"}, n, NB + lat + 1);
        check({tag, "_dev_in_bits"}, seen, s);
        got = sb.pop_front();
        check({tag, "_rx_data"}, rx_data[d], got.data);
        check({tag, "_rx_perr"}, rx_perr[d], got.perr);
        check({tag, "_dev_in_idle"}, dev_in[d], 0);
        check({tag, "_tx_ready_busy"}, {tx_ready[d], busy[d]}, 2'b01);
        if (rx_ready[d]) begin
            tick();
            check({tag, "_back_to_idle"}, {tx_ready[d], rx_valid[d], busy[d]}, 3'b100);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            check("reset_tx_ready", tx_ready[d], 1);
            check("reset_rx_valid", rx_valid[d], 0);
            check("reset_rx_data", rx_data[d], 0);
            check("reset_rx_perr", rx_perr[d], 0);
            check("reset_dev_in", dev_in[d], 0);
            check("reset_busy", busy[d], 0);
        end
        rst = 1'b0;
        tick();

        send(0, 8'hA5, "loop_A5");
        send(1, 8'h3C, "inv_3C");
        send(1, 8'hF0, "inv_F0");

        // Back-pressure: response must sit still and tx_valid must be ignored
        rx_ready[0] = 1'b0;
        send(0, 8'h5A, "bp_5A");
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h33;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_state", {rx_valid[0], tx_ready[0], busy[0], dev_in[0]}, 4'b1010);
            check("bp_rx_data", rx_data[0], 8'h5A);
        end
        tx_valid[0] = 1'b0;
        rx_ready[0] = 1'b1;
        tick();
        check("bp_release", {tx_ready[0], rx_valid[0], busy[0]}, 3'b100);

        // Reset while bit 4 of 0xFF is on the line
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'hFF;
        tick();
        tx_valid[0] = 1'b0;
        repeat (4) tick();
        check("rst_mid_bit4", {busy[0], dev_in[0]}, 2'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_ctrl", {tx_ready[0], rx_valid[0], dev_in[0], busy[0]}, 4'b1000);
        check("rst_mid_rx_data", rx_data[0], 0);

        // Reset and tx_valid together: no word may be taken
        rst = 1'b1;
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'h81;
        tick();
        rst = 1'b0;
        tx_valid[0] = 1'b0;
        check("rst_vs_valid", {tx_ready[0], busy[0]}, 2'b10);
        tick();
        check("rst_vs_valid_after", {busy[0], dev_in[0]}, 2'b00);

        send(0, 8'h01, "b2b_01");
        send(0, 8'h80, "b2b_80");

`ifdef REWIRE_ADAPTER_PARITY_EN
        send(0, 8'h07, "par_07");
        flip_par = 1'b1;
        send(0, 8'h07, "par_flip");
        flip_par = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
